// File: rtl/ecc_point_mult.sv
// rtl/ecc_point_mult.sv - affine double-and-add scalar multiplication Q = k*P over GF(p)
module ecc_point_mult #(
    parameter int W   = 8,
    parameter int K_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_prime,
    input  logic [W-1:0]   i_px,
    input  logic [W-1:0]   i_py,
    input  logic [K_W-1:0] i_k,
    output logic [W-1:0]   o_kpx,
    output logic [W-1:0]   o_kpy,
    output logic           o_inf,
    output logic           o_err,
    output logic           o_busy,
    output logic           o_done
);

    localparam int KI_W = (K_W > 1) ? $clog2(K_W) : 1;
    localparam int II_W = $clog2(W);
    localparam int CW   = $clog2(W + 1);

    localparam logic [4:0] ST_IDLE     = 5'd0;
    localparam logic [4:0] ST_CHECK    = 5'd1;
    localparam logic [4:0] ST_SCAN     = 5'd2;
    localparam logic [4:0] ST_STEP     = 5'd3;
    localparam logic [4:0] ST_DBL0     = 5'd4;
    localparam logic [4:0] ST_DBL1     = 5'd5;
    localparam logic [4:0] ST_DBL2     = 5'd6;
    localparam logic [4:0] ST_DBL3     = 5'd7;
    localparam logic [4:0] ST_ADD0     = 5'd8;
    localparam logic [4:0] ST_INV0     = 5'd9;
    localparam logic [4:0] ST_INV_SQ   = 5'd10;
    localparam logic [4:0] ST_INV_SQR  = 5'd11;
    localparam logic [4:0] ST_INV_MULR = 5'd12;
    localparam logic [4:0] ST_INV_NEXT = 5'd13;
    localparam logic [4:0] ST_LAMR     = 5'd14;
    localparam logic [4:0] ST_XR       = 5'd15;
    localparam logic [4:0] ST_X2       = 5'd16;
    localparam logic [4:0] ST_Y0       = 5'd17;
    localparam logic [4:0] ST_YR       = 5'd18;
    localparam logic [4:0] ST_MWAIT    = 5'd19;
    localparam logic [4:0] ST_DONE     = 5'd20;

    logic [4:0]     state, ret_st;
    logic [W-1:0]   a_r, p_r, px_r, py_r;
    logic [K_W-1:0] k_r;
    logic [KI_W-1:0] idx;
    logic [W-1:0]   rx, ry;
    logic           r_inf, in_add;
    logic [W-1:0]   num, den, s2, lam, xn, inv_res;
    logic [II_W-1:0] inv_i;
    logic [W-1:0]   inv_e;

    logic           mul_go, mul_run, mul_done;
    logic [W-1:0]   mul_a, mul_b, mul_sh, mul_acc;
    logic [CW-1:0]  mul_cnt;

    // x + y mod m, operands already reduced
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    // x - y mod m, operands already reduced
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) d = d + {1'b0, m};
        return d[W-1:0];
    endfunction

    // One MSB-first interleaved step: 2*acc + sel*x < 3m, so two corrections suffice
    function automatic logic [W-1:0] mul_step(input logic [W-1:0] acc, input logic [W-1:0] x,
                                              input logic sel, input logic [W-1:0] m);
        logic [W+1:0] t;
        t = {1'b0, acc, 1'b0} + (sel ? {2'b00, x} : {(W+2){1'b0}});
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    // Fermat exponent for the inverse
    assign inv_e = p_r - W'(2);

    // Shared sequential modular multiplier: mul_acc = mul_a * mul_b mod p after W steps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mul_run  <= 1'b0;
            mul_done <= 1'b0;
            mul_acc  <= '0;
            mul_sh   <= '0;
            mul_cnt  <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_go) begin
                mul_acc <= '0;
                mul_sh  <= mul_b;
                mul_cnt <= CW'(W);
                mul_run <= 1'b1;
            end else if (mul_run) begin
                mul_acc <= mul_step(mul_acc, mul_a, mul_sh[W-1], p_r);
                mul_sh  <= mul_sh << 1;
                mul_cnt <= mul_cnt - CW'(1);
                if (mul_cnt == CW'(1)) begin
                    mul_run  <= 1'b0;
                    mul_done <= 1'b1;
                end
            end
        end
    end

    // Control sequencer: scalar scan, point double/add micro-steps and Fermat inverse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            ret_st  <= ST_IDLE;
            a_r     <= '0;
            p_r     <= '0;
            px_r    <= '0;
            py_r    <= '0;
            k_r     <= '0;
            idx     <= '0;
            rx      <= '0;
            ry      <= '0;
            r_inf   <= 1'b0;
            in_add  <= 1'b0;
            num     <= '0;
            den     <= '0;
            s2      <= '0;
            lam     <= '0;
            xn      <= '0;
            inv_res <= '0;
            inv_i   <= '0;
            mul_go  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            o_kpx   <= '0;
            o_kpy   <= '0;
            o_inf   <= 1'b0;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            mul_go <= 1'b0;
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        a_r    <= i_a;
                        p_r    <= i_prime;
                        px_r   <= i_px;
                        py_r   <= i_py;
                        k_r    <= i_k;
                        o_kpx  <= '0;
                        o_kpy  <= '0;
                        o_inf  <= 1'b0;
                        o_err  <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    rx     <= '0;
                    ry     <= '0;
                    r_inf  <= 1'b1;
                    in_add <= 1'b0;
                    idx    <= KI_W'(K_W - 1);
                    if (p_r < W'(3) || !p_r[0] || px_r >= p_r || py_r >= p_r) begin
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else if (k_r == '0) begin
                        o_inf  <= 1'b1;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // leading set bit just loads R = P; in_add marks the bit as consumed
                    if (k_r[idx]) begin
                        rx     <= px_r;
                        ry     <= py_r;
                        r_inf  <= 1'b0;
                        in_add <= 1'b1;
                        state  <= ST_STEP;
                    end else begin
                        idx <= idx - KI_W'(1);
                    end
                end
                ST_STEP: begin
                    if (!in_add && k_r[idx]) begin
                        in_add <= 1'b1;
                        state  <= ST_ADD0;
                    end else begin
                        in_add <= 1'b0;
                        if (idx == '0) begin
                            o_kpx  <= rx;
                            o_kpy  <= ry;
                            o_inf  <= r_inf;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            idx   <= idx - KI_W'(1);
                            state <= ST_DBL0;
                        end
                    end
                end
                ST_DBL0: begin
                    if (r_inf || ry == '0) begin
                        r_inf <= 1'b1;
                        rx    <= '0;
                        ry    <= '0;
                        state <= ST_STEP;
                    end else begin
                        mul_a  <= rx;
                        mul_b  <= rx;
                        mul_go <= 1'b1;
                        ret_st <= ST_DBL1;
                        state  <= ST_MWAIT;
                    end
                end
                ST_DBL1: begin
                    num   <= mod_add(mul_acc, mul_acc, p_r);
                    den   <= mod_add(ry, ry, p_r);
                    state <= ST_DBL2;
                end
                ST_DBL2: begin
                    num   <= mod_add(num, mul_acc, p_r);
                    state <= ST_DBL3;
                end
                ST_DBL3: begin
                    num   <= mod_add(num, a_r, p_r);
                    s2    <= rx;
                    state <= ST_INV0;
                end
                ST_ADD0: begin
                    if (r_inf) begin
                        rx    <= px_r;
                        ry    <= py_r;
                        r_inf <= 1'b0;
                        state <= ST_STEP;
                    end else if (rx == px_r && mod_add(ry, py_r, p_r) == '0) begin
                        r_inf <= 1'b1;
                        rx    <= '0;
                        ry    <= '0;
                        state <= ST_STEP;
                    end else if (rx == px_r && ry == py_r) begin
                        state <= ST_DBL0;
                    end else begin
                        num   <= mod_sub(py_r, ry, p_r);
                        den   <= mod_sub(px_r, rx, p_r);
                        s2    <= px_r;
                        state <= ST_INV0;
                    end
                end
                ST_INV0: begin
                    inv_res <= W'(1);
                    inv_i   <= II_W'(W - 1);
                    state   <= ST_INV_SQ;
                end
                ST_INV_SQ: begin
                    mul_a  <= inv_res;
                    mul_b  <= inv_res;
                    mul_go <= 1'b1;
                    ret_st <= ST_INV_SQR;
                    state  <= ST_MWAIT;
                end
                ST_INV_SQR: begin
                    inv_res <= mul_acc;
                    if (inv_e[inv_i]) begin
                        mul_a  <= mul_acc;
                        mul_b  <= den;
                        mul_go <= 1'b1;
                        ret_st <= ST_INV_MULR;
                        state  <= ST_MWAIT;
                    end else begin
                        state <= ST_INV_NEXT;
                    end
                end
                ST_INV_MULR: begin
                    inv_res <= mul_acc;
                    state   <= ST_INV_NEXT;
                end
                ST_INV_NEXT: begin
                    if (inv_i == '0) begin
                        mul_a  <= num;
                        mul_b  <= inv_res;
                        mul_go <= 1'b1;
                        ret_st <= ST_LAMR;
                        state  <= ST_MWAIT;
                    end else begin
                        inv_i <= inv_i - II_W'(1);
                        state <= ST_INV_SQ;
                    end
                end
                ST_LAMR: begin
                    lam    <= mul_acc;
                    mul_a  <= mul_acc;
                    mul_b  <= mul_acc;
                    mul_go <= 1'b1;
                    ret_st <= ST_XR;
                    state  <= ST_MWAIT;
                end
                ST_XR: begin
                    xn    <= mod_sub(mul_acc, rx, p_r);
                    state <= ST_X2;
                end
                ST_X2: begin
                    // s2 is Rx for a double, Px for an add
                    xn    <= mod_sub(xn, s2, p_r);
                    state <= ST_Y0;
                end
                ST_Y0: begin
                    mul_a  <= lam;
                    mul_b  <= mod_sub(rx, xn, p_r);
                    mul_go <= 1'b1;
                    ret_st <= ST_YR;
                    state  <= ST_MWAIT;
                end
                ST_YR: begin
                    ry    <= mod_sub(mul_acc, ry, p_r);
                    rx    <= xn;
                    r_inf <= 1'b0;
                    state <= ST_STEP;
                end
                ST_MWAIT: begin
                    if (mul_done) state <= ret_st;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_point_mult.sv
// tb/tb_ecc_point_mult.sv - randomized self-checking bench against a repeated-addition curve model
`timescale 1ns/1ps
module tb_ecc_point_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s8;
    logic [7:0] a8, p8, x8, y8, k8, qx8, qy8;
    logic       inf8, err8, busy8, done8;
    logic       s4;
    logic [3:0] a4, p4, x4, y4, k4, qx4, qy4;
    logic       inf4, err4, busy4, done4;

    ecc_point_mult #(.W(8), .K_W(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .i_a(a8), .i_prime(p8),
        .i_px(x8), .i_py(y8), .i_k(k8), .o_kpx(qx8), .o_kpy(qy8),
        .o_inf(inf8), .o_err(err8), .o_busy(busy8), .o_done(done8)
    );

    ecc_point_mult #(.W(4), .K_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_a(a4), .i_prime(p4),
        .i_px(x4), .i_py(y4), .i_k(k4), .o_kpx(qx4), .o_kpy(qy4),
        .o_inf(inf4), .o_err(err4), .o_busy(busy4), .o_done(done4)
    );

    int n_chk = 0;
    int n_err = 0;
    int done8_cnt = 0;
    int done4_cnt = 0;

    always @(negedge clk) begin
        if (done8) done8_cnt++;
        if (done4) done4_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int md(input int v, input int p);
        int r;
        r = v % p;
        if (r < 0) r += p;
        return r;
    endfunction

    function automatic int minv(input int v, input int p);
        for (int i = 1; i < p; i++)
            if (md(v * i, p) == 1) return i;
        return 0;
    endfunction

    // textbook chord-and-tangent group law with the point at infinity
    task automatic ec_add(input int a, input int p, input bit i1, input int x1, input int y1,
                          input bit i2, input int x2, input int y2,
                          output bit io, output int xo, output int yo);
        int lam;
        if (i1) begin
            io = i2; xo = x2; yo = y2;
        end else if (i2) begin
            io = i1; xo = x1; yo = y1;
        end else if (x1 == x2 && md(y1 + y2, p) == 0) begin
            io = 1; xo = 0; yo = 0;
        end else begin
            if (x1 == x2) lam = md(md(3 * x1 * x1 + a, p) * minv(md(2 * y1, p), p), p);
            else          lam = md(md(y2 - y1, p) * minv(md(x2 - x1, p), p), p);
            xo = md(lam * lam - x1 - x2, p);
            yo = md(lam * (x1 - xo) - y1, p);
            io = 0;
        end
    endtask

    // k*P as P + P + ... + P (k times)
    task automatic ref_mult(input int a, input int p, input int x, input int y, input int k,
                            output bit io, output int xo, output int yo);
        bit ri;
        int rx, ry;
        ri = 1; rx = 0; ry = 0;
        for (int i = 0; i < k; i++) ec_add(a, p, ri, rx, ry, 0, x, y, ri, rx, ry);
        io = ri; xo = rx; yo = ry;
    endtask

    // poke > 0: second start pulse at that cycle of the job; poke < 0: start during DONE
    task automatic job8(input int a, input int p, input int x, input int y, input int k,
                        input int poke, input string tag);
        bit ei, ee;
        int ex, ey, lat;
        ee = (p < 3) || (p % 2 == 0) || (x >= p) || (y >= p);
        if (ee) begin
            ei = 0; ex = 0; ey = 0;
        end else begin
            ref_mult(a, p, x, y, k, ei, ex, ey);
        end
        @(negedge clk);
        a8 = 8'(a); p8 = 8'(p); x8 = 8'(x); y8 = 8'(y); k8 = 8'(k); s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        a8 = 8'($urandom); p8 = 8'($urandom); x8 = 8'($urandom); y8 = 8'($urandom); k8 = 8'($urandom);
        chk({tag, " busy in check"}, busy8, 1'b1);
        lat = 1;
        while (!done8 && lat < 20000) begin
            if (poke > 0 && lat == poke) begin
                s8 = 1'b1; a8 = 8'd3; p8 = 8'd23; x8 = 8'd1; y8 = 8'd2; k8 = 8'd77;
            end else begin
                s8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        s8 = 1'b0;
        chk({tag, " done"}, done8, 1'b1);
        chk({tag, " busy at done"}, busy8, 1'b0);
        chk({tag, " x"}, qx8, ex);
        chk({tag, " y"}, qy8, ey);
        chk({tag, " inf"}, inf8, ei);
        chk({tag, " err"}, err8, ee);
        if (ee || k == 0) chk({tag, " latency"}, lat, 2);
        if (poke < 0) begin
            s8 = 1'b1; p8 = 8'd23; k8 = 8'd5;
        end
        @(negedge clk);
        s8 = 1'b0;
        chk({tag, " done pulse width"}, done8, 1'b0);
        chk({tag, " idle after"}, busy8, 1'b0);
        chk({tag, " x held"}, qx8, ex);
    endtask

    task automatic job4(input int a, input int p, input int x, input int y, input int k,
                        input string tag);
        bit ei;
        int ex, ey, lat;
        ref_mult(a, p, x, y, k, ei, ex, ey);
        @(negedge clk);
        a4 = 4'(a); p4 = 4'(p); x4 = 4'(x); y4 = 4'(y); k4 = 4'(k); s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        a4 = 4'($urandom); p4 = 4'($urandom); x4 = 4'($urandom); y4 = 4'($urandom); k4 = 4'($urandom);
        lat = 1;
        while (!done4 && lat < 20000) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " done"}, done4, 1'b1);
        chk({tag, " x"}, qx4, ex);
        chk({tag, " y"}, qy4, ey);
        chk({tag, " inf"}, inf4, ei);
        chk({tag, " err"}, err4, 1'b0);
    endtask

    int tk[6] = '{1, 3, 7, 9, 10, 18};
    int tx[6] = '{5, 10, 0, 7, 7, 5};
    int ty[6] = '{1, 6, 6, 6, 11, 16};
    int primes[12] = '{5, 7, 11, 13, 17, 23, 31, 61, 97, 127, 199, 251};

    initial begin
        int c0;
        rst_n = 1'b0;
        s8 = 1'b0; a8 = '0; p8 = '0; x8 = '0; y8 = '0; k8 = '0;
        s4 = 1'b0; a4 = '0; p4 = '0; x4 = '0; y4 = '0; k4 = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy8, 1'b0);
        chk("reset done", done8, 1'b0);
        chk("reset x", qx8, 0);
        chk("reset y", qy8, 0);
        chk("reset inf", inf8, 1'b0);
        chk("reset err", err8, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        job8(2, 17, 5, 1, 2, 0, "k2");
        chk("k2 table x", qx8, 6);
        chk("k2 table y", qy8, 3);

        for (int k = 1; k <= 19; k++) begin
            job8(2, 17, 5, 1, k, 0, "sweep");
            for (int j = 0; j < 6; j++) begin
                if (tk[j] == k) begin
                    chk("table x", qx8, tx[j]);
                    chk("table y", qy8, ty[j]);
                end
            end
        end
        chk("k19 inf", inf8, 1'b1);
        job8(2, 17, 5, 1, 38, 0, "k38");
        chk("k38 inf", inf8, 1'b1);

        job8(2, 17, 5, 1, 0, 0, "k0");
        job8(2, 16, 5, 1, 2, 0, "p16");
        job8(2, 17, 17, 1, 2, 0, "px17");

        job8(2, 17, 5, 1, 2, 20, "restart ignored");
        chk("restart x", qx8, 6);
        chk("restart y", qy8, 3);
        job8(2, 17, 5, 1, 3, -1, "start in done");

        @(negedge clk);
        a8 = 8'd2; p8 = 8'd17; x8 = 8'd5; y8 = 8'd1; k8 = 8'h83; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (30) @(negedge clk);
        c0 = done8_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy8, 1'b0);
        chk("abort done", done8, 1'b0);
        chk("abort x", qx8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("abort no done", done8_cnt, c0);
        chk("abort idle", busy8, 1'b0);
        job8(2, 17, 5, 1, 2, 0, "after abort");

        for (int n = 0; n < 6; n++) begin
            int p, a, x, y, b, k;
            p = primes[$urandom_range(0, 11)];
            do begin
                a = $urandom_range(0, p - 1);
                x = $urandom_range(0, p - 1);
                y = $urandom_range(0, p - 1);
                b = md(y * y - x * x * x - a * x, p);
            end while (md(4 * a * a * a + 27 * b * b, p) == 0);
            k = $urandom_range(1, 255);
            job8(a, p, x, y, k, 0, "random");
        end

        c0 = done4_cnt;
        job4(1, 11, 0, 1, 2, "w4 k2");
        for (int n = 0; n < 9; n++) job4(1, 11, 0, 1, $urandom_range(1, 15), "w4 b2b");
        repeat (5) @(negedge clk);
        chk("w4 done count", done4_cnt - c0, 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
